mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_div_iter.sv | 51 +++++
 rtl/mdu.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the iterative multiply/divide unit.
// Latency: n/a (constants, state encodings and a helper only).
// Backpressure: n/a.
package mdu_pkg;

  localparam int XLEN = 64;

  // Decode-stage func3 encodings of the RV64M ops
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign-extend a 32-bit value to XLEN
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: restoring divider register pair, one quotient bit per step on magnitudes.
// Latency: one bit per asserted step; next-state values are exported for same-edge capture.
// Backpressure: none; the parent controls load/step.
module mdu_div_iter
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When the subtraction fits the true difference is below the divisor, so
  // the low XLEN bits of the wrapped difference are exact.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dvs_q};
    diff    = shifted[XLEN-1:0] - dvs_q;
    rem_nxt = ge ? diff : shifted[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
  end

  // Load operands on acceptance, otherwise advance one bit per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative RV64M multiply/divide unit (radix-2 shift-add, restoring divide).
// Latency: done 64 cycles after the accepting cycle (32 for W-ops), next cycle for div-by-0/overflow/illegal.
// Backpressure: busy high while iterating; start ignored while busy; flush aborts. Macro MDU_WORD_EN enables W-ops.
module mdu
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t            state;
  logic              op_div;
  logic              sgn1;
  logic              sgn2;
  logic [XLEN-1:0]   ext_a;
  logic [XLEN-1:0]   ext_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   min_neg;
  logic [XLEN-1:0]   spec_res;
  logic [XLEN-1:0]   div_dividend;
  logic              a_neg;
  logic              b_neg;
  logic              div0;
  logic              ovf;
  logic              illegal;
  logic              special;
  logic              accept;
  logic [6:0]        iter_cnt;
  logic [6:0]        cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              rneg_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_nxt;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;
`ifdef MDU_WORD_EN
  logic              word_q;
  logic [31:0]       prod_w;
`else
  logic              word_unused;
  assign word_unused = word;
`endif

  assign accept = start & ~flush & (state != ST_CALC);

  // Operand decode: signedness, W-truncation, magnitudes and the one-cycle special cases
  always_comb begin
    op_div   = func3[2];
    sgn1     = op_div ? ~func3[0] : (func3[1:0] != 2'b11);
    sgn2     = op_div ? ~func3[0] : ~func3[1];
    ext_a    = src1;
    ext_b    = src2;
    min_neg  = {1'b1, {(XLEN-1){1'b0}}};
    iter_cnt = 7'd64;
    illegal  = 1'b0;
`ifdef MDU_WORD_EN
    if (word) begin
      ext_a    = sgn1 ? sext32(src1[31:0]) : {32'b0, src1[31:0]};
      ext_b    = sgn2 ? sext32(src2[31:0]) : {32'b0, src2[31:0]};
      min_neg  = sext32(32'h8000_0000);
      iter_cnt = 7'd32;
      illegal  = ~op_div & (func3 != MDU_MUL);
    end
`endif
    a_neg   = sgn1 & ext_a[XLEN-1];
    b_neg   = sgn2 & ext_b[XLEN-1];
    mag_a   = a_neg ? -ext_a : ext_a;
    mag_b   = b_neg ? -ext_b : ext_b;
    div0    = op_div & (ext_b == '0);
    ovf     = op_div & ~func3[0] & (ext_a == min_neg) & (ext_b == '1);
    special = illegal | div0 | ovf;

    // div-by-0: quotient all ones, remainder = dividend; overflow: quotient = dividend, remainder 0
    if (illegal)
      spec_res = '0;
    else if (div0)
      spec_res = func3[1] ? ext_a : '1;
    else
      spec_res = func3[1] ? '0 : ext_a;

    // W-ops place the 32-bit dividend in the top half so 32 steps leave the quotient in the low half
    div_dividend = mag_a;
`ifdef MDU_WORD_EN
    if (word) begin
      spec_res     = sext32(spec_res[31:0]);
      div_dividend = {mag_a[31:0], 32'b0};
    end
`endif
  end

  // Shift-add multiply step: add multiplicand into the upper half when the LSB is set, then shift right
  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    acc_nxt = {sum, acc_q[XLEN-1:1]};
  end

  mdu_div_iter u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     ((state == ST_CALC) & ~flush),
    .dividend (div_dividend),
    .divisor  (mag_b),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Sign fix-up and result select from the values produced by the final step
  always_comb begin
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q ? -quo_nxt : quo_nxt;
    rem_fix  = rneg_q ? -rem_nxt : rem_nxt;
    case (op_q)
      MDU_MUL:                         calc_res = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               calc_res = quo_fix;
      default:                         calc_res = rem_fix;
    endcase
`ifdef MDU_WORD_EN
    // After 32 steps the product sits at acc[95:32]; only its low word is kept
    prod_w = neg_q ? -acc_nxt[63:32] : acc_nxt[63:32];
    if (word_q)
      calc_res = sext32((op_q == MDU_MUL) ? prod_w : calc_res[31:0]);
`endif
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
`ifdef MDU_WORD_EN
      word_q  <= 1'b0;
`endif
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_q    <= func3;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            mcand_q <= mag_a;
            acc_q   <= {{XLEN{1'b0}}, mag_b};
`ifdef MDU_WORD_EN
            word_q  <= word;
`endif
            if (special) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              result <= spec_res;
            end else begin
              state <= ST_CALC;
              busy  <= 1'b1;
              cnt_q <= iter_cnt;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            result <= calc_res;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
